// File: rtl/demultiplexer_b_reg.sv
// Five-channel registered write-back demultiplexer with per-channel valid/ack
// handshake, sticky illegal-select error flag and an accepted-write counter.
module demultiplexer_b_reg #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [W-1:0]  D,
    input  logic [2:0]    S,
    input  logic          WE,
    output logic          READY,
    output logic [W-1:0]  Y_A,
    output logic [W-1:0]  Y_B,
    output logic [W-1:0]  Y_C,
    output logic [W-1:0]  Y_D,
    output logic [W-1:0]  Y_E,
    output logic [4:0]    V,
    input  logic [4:0]    ACK,
    output logic          ERR,
    input  logic          CLR_ERR,
    output logic [CW-1:0] WCNT
);

    logic [4:0][W-1:0] y_q, y_d;
    logic [4:0]        v_q, v_d;
    logic              err_q, err_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;

    logic [4:0]        sel_oh_s;
    logic              illegal_s;
    logic              accept_s;

    // One-hot decode of the destination select; illegal codes decode to zero
    always_comb begin
        sel_oh_s  = 5'b00000;
        illegal_s = 1'b0;
        case (S)
            3'd0:    sel_oh_s = 5'b00001;
            3'd1:    sel_oh_s = 5'b00010;
            3'd2:    sel_oh_s = 5'b00100;
            3'd3:    sel_oh_s = 5'b01000;
            3'd4:    sel_oh_s = 5'b10000;
            default: illegal_s = 1'b1;
        endcase
    end

    // READY looks only at S and registered V, never at ACK, WE or D
    assign READY    = |(sel_oh_s & ~v_q);
    assign accept_s = WE & READY;

    // Next-state computation for data, valid, error and counter
    always_comb begin
        v_d = v_q & ~ACK;
        if (accept_s) begin
            v_d = v_d | sel_oh_s;
        end else begin
            v_d = v_d;
        end

        for (int i = 0; i < 5; i++) begin
            if (accept_s && sel_oh_s[i]) begin
                y_d[i] = D;
            end else begin
                y_d[i] = y_q[i];
            end
        end

        if (accept_s) begin
            wcnt_d = wcnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wcnt_d = wcnt_q;
        end

        // A new illegal write outranks a same-cycle clear
        if (WE && illegal_s) begin
            err_d = 1'b1;
        end else if (CLR_ERR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            y_q    <= '0;
            v_q    <= 5'b00000;
            err_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            y_q    <= y_d;
            v_q    <= v_d;
            err_q  <= err_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign Y_A  = y_q[0];
    assign Y_B  = y_q[1];
    assign Y_C  = y_q[2];
    assign Y_D  = y_q[3];
    assign Y_E  = y_q[4];
    assign V    = v_q;
    assign ERR  = err_q;
    assign WCNT = wcnt_q;

endmodule

// File: tb/tb_demultiplexer_b_reg.sv
// Directed bench for demultiplexer_b_reg: a behavioural model pushes the
// expected post-edge state into a queue, which is popped after each edge.
module tb_demultiplexer_b_reg;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [W-1:0]  D;
    logic [2:0]    S;
    logic          WE;
    logic          READY;
    logic [W-1:0]  Y_A, Y_B, Y_C, Y_D, Y_E;
    logic [4:0]    V;
    logic [4:0]    ACK;
    logic          ERR;
    logic          CLR_ERR;
    logic [CW-1:0] WCNT;

    demultiplexer_b_reg #(.W(W), .CW(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .D(D), .S(S), .WE(WE), .READY(READY),
        .Y_A(Y_A), .Y_B(Y_B), .Y_C(Y_C), .Y_D(Y_D), .Y_E(Y_E),
        .V(V), .ACK(ACK), .ERR(ERR), .CLR_ERR(CLR_ERR), .WCNT(WCNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0][W-1:0] y;
        logic [4:0]        v;
        logic              err;
        logic [CW-1:0]     wcnt;
    } exp_t;

    exp_t exp_q[$];

    logic [4:0][W-1:0] m_y;
    logic [4:0]        m_v;
    logic              m_err;
    logic [CW-1:0]     m_wcnt;
    bit                m_known = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic step(input logic rst_n, input logic we, input logic [2:0] s,
                        input logic [W-1:0] d, input logic [4:0] ack,
                        input logic clr, input string tag);
        logic              legal;
        logic              exp_ready;
        logic              acc;
        exp_t              e;
        exp_t              got;
        logic [4:0][W-1:0] obs;
        @(negedge CLK);
        RST_N = rst_n; WE = we; S = s; D = d; ACK = ack; CLR_ERR = clr;
        #1;
        legal     = (s <= 3'd4);
        exp_ready = legal ? ~m_v[s] : 1'b0;
        if (m_known) begin
            checks++;
            assert (READY === exp_ready) else begin
                failures++;
                $error("FAIL %s ready: observed=%b expected=%b", tag, READY, exp_ready);
            end
        end
        acc = we && exp_ready;
        if (!rst_n) begin
            m_y = '0; m_v = 5'b00000; m_err = 1'b0; m_wcnt = '0;
            m_known = 1'b1;
        end else begin
            m_v = m_v & ~ack;
            if (acc) begin
                m_y[s] = d;
                m_v[s] = 1'b1;
                m_wcnt = m_wcnt + 8'd1;
            end
            if (we && !legal) m_err = 1'b1;
            else if (clr)     m_err = 1'b0;
        end
        e.y = m_y; e.v = m_v; e.err = m_err; e.wcnt = m_wcnt;
        exp_q.push_back(e);

        @(posedge CLK);
        #1;
        got = exp_q.pop_front();
        obs = {Y_E, Y_D, Y_C, Y_B, Y_A};
        for (int i = 0; i < 5; i++) begin
            checks++;
            assert (obs[i] === got.y[i]) else begin
                failures++;
                $error("FAIL %s y[%0d]: observed=%h expected=%h", tag, i, obs[i], got.y[i]);
            end
        end
        checks++;
        assert (V === got.v) else begin
            failures++;
            $error("FAIL %s v: observed=%b expected=%b", tag, V, got.v);
        end
        checks++;
        assert (ERR === got.err) else begin
            failures++;
            $error("FAIL %s err: observed=%b expected=%b", tag, ERR, got.err);
        end
        checks++;
        assert (WCNT === got.wcnt) else begin
            failures++;
            $error("FAIL %s wcnt: observed=%h expected=%h", tag, WCNT, got.wcnt);
        end
    endtask

    initial begin
        int         n;
        logic [2:0] c;
        logic [4:0] oh;
        RST_N = 1'b0; WE = 1'b0; S = 3'd0; D = 8'h00; ACK = 5'b00000; CLR_ERR = 1'b0;

        step(1'b0, 1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, "reset0");
        step(1'b0, 1'b0, 3'd0, 8'h00, 5'b00000, 1'b0, "reset1");

        // Fill all five channels
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 3'(i), 8'(8'h11 * (i + 1)), 5'b00000, 1'b0, "fill");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 3'(i), 8'h00, 5'b00000, 1'b0, "full_ready");

        // Back-pressure on B, then release with ACK
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 3'd1, 8'hAA, 5'b00000, 1'b0, "blocked");
        step(1'b1, 1'b1, 3'd1, 8'hAA, 5'b00010, 1'b0, "ack_b");
        step(1'b1, 1'b1, 3'd1, 8'hAA, 5'b00000, 1'b0, "accept_b");

        // Illegal select and error clear
        step(1'b1, 1'b1, 3'd6, 8'hFF, 5'b00000, 1'b0, "illegal");
        step(1'b1, 1'b0, 3'd6, 8'hFF, 5'b00000, 1'b0, "err_hold");
        step(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, "err_clr");
        step(1'b1, 1'b1, 3'd7, 8'h12, 5'b00000, 1'b1, "set_wins");
        step(1'b1, 1'b0, 3'd0, 8'h00, 5'b00000, 1'b1, "err_clr2");

        // Concurrent write to C and ACK of A
        step(1'b1, 1'b0, 3'd0, 8'h00, 5'b11110, 1'b0, "ack_bcde");
        step(1'b1, 1'b1, 3'd2, 8'h5A, 5'b00001, 1'b0, "wr_c_ack_a");

        // Drive accepted writes until the counter wraps to zero
        n = 256 - int'(m_wcnt);
        for (int i = 0; i < n; i++) begin
            c  = 3'(i % 5);
            oh = 5'b00001 << c;
            step(1'b1, 1'b1, c, 8'(i), ~oh, 1'b0, "wrap");
        end
        checks++;
        assert (WCNT === 8'h00 && ERR === 1'b0) else begin
            failures++;
            $error("FAIL wrap_zero: observed wcnt=%h err=%b expected wcnt=00 err=0", WCNT, ERR);
        end

        // Reset on the same edge as an accepted write to D
        step(1'b1, 1'b0, 3'd0, 8'h00, 5'b11111, 1'b0, "ack_all");
        step(1'b0, 1'b1, 3'd3, 8'h77, 5'b00000, 1'b0, "reset_mid");
        step(1'b1, 1'b1, 3'd4, 8'h3C, 5'b00001, 1'b0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demultiplexer_b_reg.md
Name: demultiplexer_b_reg

Overview:
- 5-channel, 8-bit registered demultiplexer: the inverse of the 5-way source select on the datapath bus.
- Routes one write-back bus value to one of five destination holding registers (A–E), selected by a 3-bit code.
- Each destination has a valid flag and a consumer acknowledge, so the producer is back-pressured per channel.
- Sits between the ALU/data-bus result and the destination latches; the encoding of S is identical to the source mux (0=A … 4=E).

Parameters:
- W, 8, data width of the input bus and of each destination register.
- CW, 8, width of the accepted-write counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  synchronous active-low reset.
- D  input  W  write-back data.
- S  input  3  destination select: 000=A, 001=B, 010=C, 011=D, 100=E, 101–111 illegal.
- WE  input  1  write request, qualified by READY.
- READY  output  1  combinational; 1 when S is legal (≤4) and V[S]==0.
- Y_A, Y_B, Y_C, Y_D, Y_E  output  W each  destination holding registers.
- V  output  5  per-channel valid flags; bit0=A … bit4=E.
- ACK  input  5  per-channel consumer acknowledge; bit i clears V[i].
- ERR  output  1  sticky illegal-select flag.
- CLR_ERR  input  1  clears ERR.
- WCNT  output  CW  count of accepted writes, wraps modulo 2^CW.

Behaviour:
- Reset is synchronous only: reset is sampled solely on a rising CLK edge with RST_N==0. On that edge:
  - Y_A–Y_E = 0, V = 5'b00000, ERR = 0, WCNT = 0.
  - Reset overrides every other input in the same cycle, including an in-flight WE or ACK.
- Accept: a write is accepted when WE && READY at the rising edge. Then:
  - Y_sel <= D and V[sel] <= 1 at that edge; data and valid are visible the cycle after acceptance (latency 1).
  - WCNT <= WCNT+1; FFFF…→0 wrap, no saturation.
- Non-selected registers hold their value; Y_x changes only on an accepted write to channel x.
- Blocked: WE with legal S and V[S]==1 is ignored (no data change, no count, no error). The producer holds D/S/WE until READY.
- Illegal select: WE with S in 101–111:
  - No register, V, or WCNT change.
  - ERR <= 1 at that edge. READY is 0 whenever S is illegal.
- ERR clear:
  - CLR_ERR clears ERR at the edge.
  - If CLR_ERR and an illegal WE occur in the same cycle, set wins (ERR=1).
- ACK:
  - ACK[i] at an edge clears V[i]. Y_x retains its data after ACK.
  - ACK on a channel with V[i]==0 has no effect.
  - Multiple ACK bits may be set together.
- Simultaneous events:
  - Write to channel j and ACK[i] with i≠j: both take effect.
  - ACK[j] in the same cycle as WE targeting j: READY was already 0 (V[j]==1), so the write is not accepted; V[j] clears and READY rises the next cycle.
  - READY does not look ahead at ACK. This keeps READY free of a combinational path from ACK.
- READY depends only on S and the registered V, so there is no combinational path from WE or D.
- Mid-operation reset: a write accepted in the reset cycle is discarded; all state shows reset values after the edge.

Test Plan:
- Reset, then fill: hold RST_N=0 for 2 edges → all Y=0, V=0, WCNT=0. Then WE=1 with S=000..100 and D=11,22,33,44,55 on successive cycles → Y_A..Y_E=11..55, V=11111, WCNT=5, READY=0 for every legal S.
- Back-pressure:
  - V[B]=1, WE=1, S=001, D=AA for 3 cycles → Y_B unchanged, WCNT unchanged.
  - Then assert ACK[1] for 1 cycle → V[1]=0 next cycle, READY=1, AA accepted the following edge, V[1]=1.
- Illegal select: WE=1, S=110, D=FF → no Y/V/WCNT change, READY=0, ERR=1. ERR persists until CLR_ERR=1 → ERR=0. Then CLR_ERR=1 together with WE, S=111 → ERR stays 1.
- Concurrent write and ACK: V=00001, WE to S=010 (C) with D=5A, and ACK=00001 in the same cycle → next cycle V=00100, Y_C=5A, Y_A unchanged.
- Counter wrap (CW=8): perform 256 accepted writes, alternating ACKs to keep channels free → WCNT=00 after the 256th, ERR=0.
- Reset mid-operation: RST_N=0 on the same edge as an accepted WE to S=011 → Y_D=0, V=0, WCNT=0 after the edge.
